// File: rtl/rv32i_mem_arbiter_if.sv
// Bus bundle between the RV32I core ports (fetch + data), the arbiter and
// the shared single-ported memory. The arbiter uses the slave view; the
// core/memory side uses the master view.
interface rv32i_mem_arbiter_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ack;
  logic [31:0] i_rdata;

  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wmask;
  logic        d_ack;
  logic [31:0] d_rdata;

  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_rdata;

  logic        busy;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_wmask, mem_rdata,
    output i_ack, i_rdata, d_ack, d_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, mem_wmask, busy
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_wmask, mem_rdata,
    input  i_ack, i_rdata, d_ack, d_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, mem_wmask, busy
  );
endinterface

// File: rtl/rv32i_mem_arbiter.sv
// Shares one single-ported synchronous RAM between the instruction-fetch
// and data ports of an RV32I core. Each access runs IDLE -> ISSUE ->
// WAIT (READ_LATENCY cycles) -> RESP, and every output is a register.
module rv32i_mem_arbiter #(
  parameter int READ_LATENCY = 1,
  parameter int ARB_MODE     = 0
) (
  input logic              clk,
  input logic              rst_n,
  rv32i_mem_arbiter_if.slave bus
);

  // Latencies outside 1..4 are not supported, so they are pinned to the range.
  localparam int LAT = (READ_LATENCY < 1) ? 1 :
                       (READ_LATENCY > 4) ? 4 : READ_LATENCY;
  localparam logic [2:0] LAT_CNT = 3'(LAT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  typedef enum logic {GRANT_I, GRANT_D} grant_t;

  state_t     state;
  grant_t     grant;
  grant_t     last_grant;
  logic       grant_store;
  logic [2:0] wait_cnt;
  logic       pick_data;

  // Winner selection: a lone request always wins; a tie goes to data in
  // fixed-priority mode, otherwise to the port that did not win last time.
  always_comb begin
    pick_data = 1'b0;
    if (bus.i_req && bus.d_req) begin
      if (ARB_MODE != 0) pick_data = 1'b1;
      else               pick_data = (last_grant == GRANT_I);
    end else begin
      pick_data = bus.d_req;
    end
  end

  // Transaction sequencer; payload is latched into the memory outputs at grant.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      grant         <= GRANT_I;
      last_grant    <= GRANT_D;
      grant_store   <= 1'b0;
      wait_cnt      <= 3'd0;
      bus.i_ack     <= 1'b0;
      bus.i_rdata   <= 32'h0;
      bus.d_ack     <= 1'b0;
      bus.d_rdata   <= 32'h0;
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= 32'h0;
      bus.mem_wdata <= 32'h0;
      bus.mem_wmask <= 4'h0;
      bus.busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.i_ack <= 1'b0;
          bus.d_ack <= 1'b0;
          if (bus.i_req || bus.d_req) begin
            state      <= ISSUE;
            bus.busy   <= 1'b1;
            bus.mem_en <= 1'b1;
            if (pick_data) begin
              grant         <= GRANT_D;
              last_grant    <= GRANT_D;
              grant_store   <= bus.d_we;
              bus.mem_we    <= bus.d_we;
              bus.mem_addr  <= bus.d_addr;
              bus.mem_wdata <= bus.d_wdata;
              bus.mem_wmask <= bus.d_we ? bus.d_wmask : 4'h0;
            end else begin
              grant         <= GRANT_I;
              last_grant    <= GRANT_I;
              grant_store   <= 1'b0;
              bus.mem_we    <= 1'b0;
              bus.mem_addr  <= bus.i_addr;
              bus.mem_wdata <= 32'h0;
              bus.mem_wmask <= 4'h0;
            end
          end
        end
        ISSUE: begin
          bus.mem_en    <= 1'b0;
          bus.mem_we    <= 1'b0;
          bus.mem_wmask <= 4'h0;
          wait_cnt      <= LAT_CNT;
          state         <= WAIT;
        end
        WAIT: begin
          if (wait_cnt == 3'd1) begin
            wait_cnt <= 3'd0;
            state    <= RESP;
            if (grant == GRANT_I) begin
              bus.i_rdata <= bus.mem_rdata;
              bus.i_ack   <= 1'b1;
            end else begin
              if (!grant_store) bus.d_rdata <= bus.mem_rdata;
              bus.d_ack <= 1'b1;
            end
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        RESP: begin
          bus.i_ack <= 1'b0;
          bus.d_ack <= 1'b0;
          bus.busy  <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// Directed bench for rv32i_mem_arbiter. Three instances cover the
// parameter sets: A (latency 1, round-robin), B (latency 1, data
// priority) and C (latency 3, round-robin). Inputs change and outputs
// are sampled on the falling edge; the DUTs act on the rising edge.
module tb_rv32i_mem_arbiter;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  rv32i_mem_arbiter_if bus_a ();
  rv32i_mem_arbiter_if bus_b ();
  rv32i_mem_arbiter_if bus_c ();

  rv32i_mem_arbiter #(.READ_LATENCY(1), .ARB_MODE(0)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  rv32i_mem_arbiter #(.READ_LATENCY(1), .ARB_MODE(1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));
  rv32i_mem_arbiter #(.READ_LATENCY(3), .ARB_MODE(0)) dut_c (.clk(clk), .rst_n(rst_n), .bus(bus_c));

  // Free-running clock, 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory A: 256-word RAM, byte-masked writes, 1-cycle read; read data is
  // zero in any cycle that is not exactly one after a read strobe.
  logic [31:0] mem_a [0:255];
  initial begin
    for (int k = 0; k < 256; k++) mem_a[k] = {16'hC0DE, 8'h00, 8'(k)};
    mem_a[64] = 32'h0050_0093;
  end
  always @(posedge clk) begin
    bus_a.mem_rdata <= (bus_a.mem_en && !bus_a.mem_we) ? mem_a[bus_a.mem_addr[9:2]] : 32'h0;
    if (bus_a.mem_en && bus_a.mem_we)
      for (int b = 0; b < 4; b++)
        if (bus_a.mem_wmask[b]) mem_a[bus_a.mem_addr[9:2]][8*b +: 8] <= bus_a.mem_wdata[8*b +: 8];
  end

  // Memory B: read-only, returns the inverted address one cycle after the strobe.
  always @(posedge clk)
    bus_b.mem_rdata <= bus_b.mem_en ? ~bus_b.mem_addr : 32'h0;

  // Memory C: read-only, returns address + 0x12345678 three cycles after the strobe.
  logic [31:0] c_p1, c_p2;
  always @(posedge clk) begin
    c_p1            <= bus_c.mem_en ? bus_c.mem_addr + 32'h1234_5678 : 32'h0;
    c_p2            <= c_p1;
    bus_c.mem_rdata <= c_p2;
  end

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (bus_a.mem_en !== 1'b0)  begin n_fail++; $display("[TB] FAIL reset_mem_en: got %h want 0", bus_a.mem_en); end
    n_checks++; if (bus_a.mem_we !== 1'b0)  begin n_fail++; $display("[TB] FAIL reset_mem_we: got %h want 0", bus_a.mem_we); end
    n_checks++; if (bus_a.busy !== 1'b0)    begin n_fail++; $display("[TB] FAIL reset_busy: got %h want 0", bus_a.busy); end
    n_checks++; if ({bus_a.i_ack, bus_a.d_ack} !== 2'b00) begin n_fail++; $display("[TB] FAIL reset_acks: got %b want 00", {bus_a.i_ack, bus_a.d_ack}); end
    n_checks++; if (bus_a.mem_addr !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_mem_addr: got %h want 0", bus_a.mem_addr); end
    n_checks++; if (bus_a.i_rdata !== 32'h0)  begin n_fail++; $display("[TB] FAIL reset_i_rdata: got %h want 0", bus_a.i_rdata); end
    n_checks++; if (bus_a.d_rdata !== 32'h0)  begin n_fail++; $display("[TB] FAIL reset_d_rdata: got %h want 0", bus_a.d_rdata); end
    n_checks++; if ({bus_b.busy, bus_c.busy} !== 2'b00) begin n_fail++; $display("[TB] FAIL reset_busy_bc: got %b want 00", {bus_b.busy, bus_c.busy}); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_fetch;
    bus_a.i_addr = 32'h100;
    bus_a.i_req  = 1'b1;
    @(negedge clk);
    n_checks++; if (bus_a.mem_en !== 1'b1)      begin n_fail++; $display("[TB] FAIL fetch_mem_en: got %h want 1", bus_a.mem_en); end
    n_checks++; if (bus_a.mem_addr !== 32'h100) begin n_fail++; $display("[TB] FAIL fetch_mem_addr: got %h want 100", bus_a.mem_addr); end
    n_checks++; if (bus_a.mem_we !== 1'b0)      begin n_fail++; $display("[TB] FAIL fetch_mem_we: got %h want 0", bus_a.mem_we); end
    n_checks++; if (bus_a.busy !== 1'b1)        begin n_fail++; $display("[TB] FAIL fetch_busy_t1: got %h want 1", bus_a.busy); end
    @(negedge clk);
    n_checks++; if (bus_a.i_ack !== 1'b0)       begin n_fail++; $display("[TB] FAIL fetch_early_ack: got %h want 0", bus_a.i_ack); end
    n_checks++; if (bus_a.mem_en !== 1'b0)      begin n_fail++; $display("[TB] FAIL fetch_mem_en_t2: got %h want 0", bus_a.mem_en); end
    @(negedge clk);
    n_checks++; if (bus_a.i_ack !== 1'b1)       begin n_fail++; $display("[TB] FAIL fetch_i_ack: got %h want 1", bus_a.i_ack); end
    n_checks++; if (bus_a.i_rdata !== 32'h0050_0093) begin n_fail++; $display("[TB] FAIL fetch_i_rdata: got %h want 00500093", bus_a.i_rdata); end
    n_checks++; if (bus_a.d_ack !== 1'b0)       begin n_fail++; $display("[TB] FAIL fetch_d_ack: got %h want 0", bus_a.d_ack); end
    n_checks++; if (bus_a.busy !== 1'b1)        begin n_fail++; $display("[TB] FAIL fetch_busy_t3: got %h want 1", bus_a.busy); end
    bus_a.i_req = 1'b0;
    @(negedge clk);
    n_checks++; if (bus_a.i_ack !== 1'b0)       begin n_fail++; $display("[TB] FAIL fetch_ack_pulse: got %h want 0", bus_a.i_ack); end
    n_checks++; if (bus_a.busy !== 1'b0)        begin n_fail++; $display("[TB] FAIL fetch_busy_t4: got %h want 0", bus_a.busy); end
  endtask

  task automatic test_store_load;
    bus_a.d_addr  = 32'h200;
    bus_a.d_we    = 1'b1;
    bus_a.d_wdata = 32'hDEAD_BEEF;
    bus_a.d_wmask = 4'b0011;
    bus_a.d_req   = 1'b1;
    @(negedge clk);
    n_checks++; if (bus_a.mem_we !== 1'b1)          begin n_fail++; $display("[TB] FAIL store_mem_we: got %h want 1", bus_a.mem_we); end
    n_checks++; if (bus_a.mem_wmask !== 4'b0011)    begin n_fail++; $display("[TB] FAIL store_mem_wmask: got %b want 0011", bus_a.mem_wmask); end
    n_checks++; if (bus_a.mem_wdata !== 32'hDEAD_BEEF) begin n_fail++; $display("[TB] FAIL store_mem_wdata: got %h want deadbeef", bus_a.mem_wdata); end
    n_checks++; if (bus_a.mem_addr !== 32'h200)     begin n_fail++; $display("[TB] FAIL store_mem_addr: got %h want 200", bus_a.mem_addr); end
    repeat (2) @(negedge clk);
    n_checks++; if (bus_a.d_ack !== 1'b1)           begin n_fail++; $display("[TB] FAIL store_d_ack: got %h want 1", bus_a.d_ack); end
    n_checks++; if (bus_a.d_rdata !== 32'h0)        begin n_fail++; $display("[TB] FAIL store_d_rdata_kept: got %h want 0", bus_a.d_rdata); end
    n_checks++; if (bus_a.i_ack !== 1'b0)           begin n_fail++; $display("[TB] FAIL store_i_ack: got %h want 0", bus_a.i_ack); end
    bus_a.d_req = 1'b0;
    @(negedge clk);
    bus_a.d_we    = 1'b0;
    bus_a.d_wmask = 4'hF;
    bus_a.d_req   = 1'b1;
    @(negedge clk);
    n_checks++; if (bus_a.mem_we !== 1'b0)          begin n_fail++; $display("[TB] FAIL load_mem_we: got %h want 0", bus_a.mem_we); end
    n_checks++; if (bus_a.mem_wmask !== 4'h0)       begin n_fail++; $display("[TB] FAIL load_mem_wmask: got %b want 0000", bus_a.mem_wmask); end
    n_checks++; if (bus_a.mem_addr !== 32'h200)     begin n_fail++; $display("[TB] FAIL load_mem_addr: got %h want 200", bus_a.mem_addr); end
    bus_a.d_addr = 32'h204;
    repeat (2) @(negedge clk);
    n_checks++; if (bus_a.d_ack !== 1'b1)           begin n_fail++; $display("[TB] FAIL load_d_ack: got %h want 1", bus_a.d_ack); end
    n_checks++; if (bus_a.d_rdata !== 32'hC0DE_BEEF) begin n_fail++; $display("[TB] FAIL load_d_rdata: got %h want c0debeef", bus_a.d_rdata); end
    bus_a.d_req  = 1'b0;
    bus_a.d_addr = 32'h200;
    @(negedge clk);
  endtask

  task automatic test_round_robin;
    logic [1:0] exp;
    rst_n = 1'b0;
    @(negedge clk);
    bus_a.i_addr = 32'h100;
    bus_a.d_addr = 32'h200;
    bus_a.d_we   = 1'b0;
    bus_a.i_req  = 1'b1;
    bus_a.d_req  = 1'b1;
    rst_n        = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      exp = (c == 3 || c == 11) ? 2'b10 : (c == 7 || c == 15) ? 2'b01 : 2'b00;
      n_checks++; if ({bus_a.i_ack, bus_a.d_ack} !== exp) begin n_fail++; $display("[TB] FAIL rr_acks_c%0d: got %b want %b", c, {bus_a.i_ack, bus_a.d_ack}, exp); end
      if (c == 3) begin
        n_checks++; if (bus_a.i_rdata !== 32'h0050_0093) begin n_fail++; $display("[TB] FAIL rr_i_rdata: got %h want 00500093", bus_a.i_rdata); end
      end
      if (c == 7) begin
        n_checks++; if (bus_a.d_rdata !== 32'hC0DE_BEEF) begin n_fail++; $display("[TB] FAIL rr_d_rdata: got %h want c0debeef", bus_a.d_rdata); end
      end
    end
    bus_a.i_req = 1'b0;
    bus_a.d_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_fixed_priority;
    logic [1:0] exp;
    bus_b.i_addr = 32'h300;
    bus_b.d_addr = 32'h80;
    bus_b.d_we   = 1'b0;
    bus_b.i_req  = 1'b1;
    bus_b.d_req  = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      exp = (c == 15) ? 2'b10 : (c == 3 || c == 7 || c == 11) ? 2'b01 : 2'b00;
      n_checks++; if ({bus_b.i_ack, bus_b.d_ack} !== exp) begin n_fail++; $display("[TB] FAIL fp_acks_c%0d: got %b want %b", c, {bus_b.i_ack, bus_b.d_ack}, exp); end
      if (c == 3) begin
        n_checks++; if (bus_b.d_rdata !== 32'hFFFF_FF7F) begin n_fail++; $display("[TB] FAIL fp_d_rdata: got %h want ffffff7f", bus_b.d_rdata); end
      end
      if (c == 11) bus_b.d_req = 1'b0;
      if (c == 15) begin
        n_checks++; if (bus_b.i_rdata !== 32'hFFFF_FCFF) begin n_fail++; $display("[TB] FAIL fp_i_rdata: got %h want fffffcff", bus_b.i_rdata); end
      end
    end
    bus_b.i_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_latency3;
    bus_c.d_addr = 32'h40;
    bus_c.d_we   = 1'b0;
    bus_c.d_req  = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      n_checks++; if (bus_c.mem_en !== (c == 1)) begin n_fail++; $display("[TB] FAIL lat3_mem_en_c%0d: got %h want %h", c, bus_c.mem_en, (c == 1)); end
      n_checks++; if (bus_c.d_ack !== (c == 5))  begin n_fail++; $display("[TB] FAIL lat3_d_ack_c%0d: got %h want %h", c, bus_c.d_ack, (c == 5)); end
      if (c == 4) begin
        n_checks++; if (bus_c.d_rdata !== 32'h0) begin n_fail++; $display("[TB] FAIL lat3_d_rdata_early: got %h want 0", bus_c.d_rdata); end
      end
      if (c == 5) begin
        n_checks++; if (bus_c.d_rdata !== 32'h1234_56B8) begin n_fail++; $display("[TB] FAIL lat3_d_rdata: got %h want 123456b8", bus_c.d_rdata); end
        n_checks++; if (bus_c.busy !== 1'b1) begin n_fail++; $display("[TB] FAIL lat3_busy: got %h want 1", bus_c.busy); end
        bus_c.d_req = 1'b0;
      end
    end
  endtask

  task automatic test_reset_mid_wait;
    bus_a.i_addr = 32'h100;
    bus_a.i_req  = 1'b1;
    @(negedge clk);
    n_checks++; if (bus_a.mem_en !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_mw_issue: got %h want 1", bus_a.mem_en); end
    @(negedge clk);
    n_checks++; if (bus_a.busy !== 1'b1)   begin n_fail++; $display("[TB] FAIL rst_mw_busy_wait: got %h want 1", bus_a.busy); end
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++; if (bus_a.i_ack !== 1'b0)  begin n_fail++; $display("[TB] FAIL rst_mw_no_ack: got %h want 0", bus_a.i_ack); end
    n_checks++; if (bus_a.busy !== 1'b0)   begin n_fail++; $display("[TB] FAIL rst_mw_busy: got %h want 0", bus_a.busy); end
    n_checks++; if ({bus_a.mem_en, bus_a.mem_we} !== 2'b00) begin n_fail++; $display("[TB] FAIL rst_mw_mem: got %b want 00", {bus_a.mem_en, bus_a.mem_we}); end
    n_checks++; if (bus_a.i_rdata !== 32'h0) begin n_fail++; $display("[TB] FAIL rst_mw_i_rdata: got %h want 0", bus_a.i_rdata); end
    rst_n        = 1'b1;
    bus_a.d_addr = 32'h200;
    bus_a.d_we   = 1'b0;
    bus_a.d_req  = 1'b1;
    @(negedge clk);
    n_checks++; if (bus_a.mem_addr !== 32'h100) begin n_fail++; $display("[TB] FAIL rst_mw_tie_addr: got %h want 100", bus_a.mem_addr); end
    repeat (2) @(negedge clk);
    n_checks++; if ({bus_a.i_ack, bus_a.d_ack} !== 2'b10) begin n_fail++; $display("[TB] FAIL rst_mw_tie_ack: got %b want 10", {bus_a.i_ack, bus_a.d_ack}); end
    n_checks++; if (bus_a.i_rdata !== 32'h0050_0093) begin n_fail++; $display("[TB] FAIL rst_mw_i_rdata2: got %h want 00500093", bus_a.i_rdata); end
    bus_a.i_req = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++; if ({bus_a.i_ack, bus_a.d_ack} !== 2'b01) begin n_fail++; $display("[TB] FAIL rst_mw_d_ack: got %b want 01", {bus_a.i_ack, bus_a.d_ack}); end
    bus_a.d_req = 1'b0;
    @(negedge clk);
  endtask

  // Test sequence.
  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    bus_a.i_req = 1'b0; bus_a.i_addr = 32'h0; bus_a.d_req = 1'b0; bus_a.d_we = 1'b0;
    bus_a.d_addr = 32'h0; bus_a.d_wdata = 32'h0; bus_a.d_wmask = 4'h0;
    bus_b.i_req = 1'b0; bus_b.i_addr = 32'h0; bus_b.d_req = 1'b0; bus_b.d_we = 1'b0;
    bus_b.d_addr = 32'h0; bus_b.d_wdata = 32'h0; bus_b.d_wmask = 4'h0;
    bus_c.i_req = 1'b0; bus_c.i_addr = 32'h0; bus_c.d_req = 1'b0; bus_c.d_we = 1'b0;
    bus_c.d_addr = 32'h0; bus_c.d_wdata = 32'h0; bus_c.d_wmask = 4'h0;
    test_reset();
    test_single_fetch();
    test_store_load();
    test_round_robin();
    test_fixed_priority();
    test_latency3();
    test_reset_mid_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rv32i_mem_arbiter.md
Name: rv32i_mem_arbiter

Overview:
- Shares one single-ported synchronous memory between two requesters: the core's instruction-fetch port and its data load/store port.
- Lets instruction and data live in one unified RAM instead of a split ROM/RAM.
- Sequences each access through a small FSM with a configurable memory read latency.
- Returns the result to the winning requester with a one-cycle ack pulse.

Parameters:
- READ_LATENCY, 1, cycles from the mem_en cycle to valid mem_rdata; legal range 1..4.
- ARB_MODE, 0, 0 = round-robin between ports; 1 = data port has fixed priority.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- i_req  input  1  instruction fetch request; held high until i_ack.
- i_addr  input  32  fetch address; stable while i_req is high.
- i_ack  output  1  one-cycle pulse; fetch complete, i_rdata valid.
- i_rdata  output  32  fetched word; registered.
- d_req  input  1  data request; held high until d_ack.
- d_we  input  1  1 = store, 0 = load.
- d_addr  input  32  data address.
- d_wdata  input  32  store data.
- d_wmask  input  4  store byte mask {b3,b2,b1,b0}.
- d_ack  output  1  one-cycle pulse; access complete.
- d_rdata  output  32  load data; registered.
- mem_en  output  1  memory access strobe; one cycle per transaction.
- mem_we  output  1  memory write enable.
- mem_addr  output  32  memory address.
- mem_wdata  output  32  memory write data.
- mem_wmask  output  4  memory write mask.
- mem_rdata  input  32  memory read data; valid READ_LATENCY cycles after mem_en.
- busy  output  1  high whenever FSM is not in IDLE.

Behaviour:
- All outputs are registered.
- Reset values: all outputs 0, FSM = IDLE, wait counter 0, last_grant = DATA.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - No request: stay in IDLE.
  - Any request: choose a winner, latch grant, drive memory outputs next cycle, go to ISSUE.
- Arbitration when both requests are high in IDLE:
  - ARB_MODE=0: grant the port that did not win last; last_grant updates on every grant.
  - ARB_MODE=1: data always wins.
  - A single request is always granted.
- ISSUE (one cycle):
  - mem_en=1; mem_addr = latched address.
  - Instruction grant: mem_we=0, mem_wmask=0.
  - Data grant: mem_we=d_we, mem_wdata=d_wdata, mem_wmask = d_we ? d_wmask : 0.
  - Load counter with READ_LATENCY, go to WAIT.
- WAIT:
  - mem_en=0; mem_we=0; mem_wmask=0.
  - Counter decrements each cycle; WAIT lasts exactly READ_LATENCY cycles.
  - At the end of the last WAIT cycle, capture mem_rdata:
    - into i_rdata for an instruction grant;
    - into d_rdata for a data load;
    - neither rdata register changes on a store.
  - Then go to RESP.
- RESP (one cycle): assert ack for the granted port only, go to IDLE.
- Latency: request first seen in IDLE at cycle T0; ISSUE at T1; ack at T2+READ_LATENCY.
  - With READ_LATENCY=1, ack arrives at T3.
  - Throughput is one transaction per READ_LATENCY+3 cycles.
- Requester rules:
  - req and payload stay stable until the ack cycle.
  - req high in the cycle after ack is a new transaction.
  - The losing port's req remains pending and is served in the next IDLE.
- Payload is sampled at grant time; changes after grant do not affect the transaction.
- Simultaneous ack on both ports never occurs.
- rdata registers hold their value until the next capture for that port.
- Reset mid-transaction (any state): next cycle FSM = IDLE, mem_en=0, mem_we=0, no ack issued, in-flight access dropped, last_grant = DATA.
- Out-of-range READ_LATENCY values are unsupported; implementation clamps to 1..4.

Test Plan:
- Single fetch, READ_LATENCY=1:
  - Stimulus: i_req=1, i_addr=0x100 at T0; memory returns 0x00500093.
  - Required: mem_en=1, mem_addr=0x100, mem_we=0 at T1; i_ack=1, i_rdata=0x00500093 at T3; busy high T1..T3.
- Store then load, same address:
  - Stimulus: d_req, d_we=1, d_addr=0x200, d_wdata=0xDEADBEEF, d_wmask=4'b0011.
  - Required: mem_we=1, mem_wmask=4'b0011 in ISSUE; d_ack at T3; d_rdata unchanged.
  - Follow-up load of 0x200 returns the memory model's contents in d_rdata at its ack.
- Round-robin contention, ARB_MODE=0:
  - Stimulus: i_req and d_req both held high from reset release.
  - Required: grant order I, D, I, D; acks alternate, one every 4 cycles; no dual ack.
- Fixed priority, ARB_MODE=1:
  - Stimulus: both requests high, d_req re-asserted immediately after each d_ack for 3 transactions.
  - Required: three d_acks before the first i_ack.
- READ_LATENCY=3:
  - Stimulus: single load at 0x40.
  - Required: mem_en at T1; mem_rdata sampled at the end of T4; d_ack at T5.
- Reset mid-WAIT:
  - Stimulus: rst_n=0 for one cycle during WAIT of a fetch.
  - Required: no i_ack; all outputs 0 next cycle; a later tie grants I first.
